// File: rtl/crc32_stream_checker_if.sv
// Word stream into the CRC-32 checker: 32-bit data, last-word marker and valid/ready handshake.
interface crc32_stream_checker_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/crc32_stream_checker.sv
// Receive-side CRC-32 checker (MSB-first, non-reflected, no final XOR); last word carries the CRC.
// Optional saturating failed-packet counter on err_cnt when CRC32_CHK_ERRCNT_EN is defined.
module crc32_stream_checker #(
  parameter logic [31:0] CRC_POLY       = 32'h04C11DB7,
  parameter logic [31:0] CRC_INIT       = 32'h00000000,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  crc32_stream_checker_if.slave        s,
  output logic                         res_valid,
  output logic                         res_ok,
  output logic [31:0]                  res_crc,
  output logic                         busy
`ifdef CRC32_CHK_ERRCNT_EN
  ,
  output logic [15:0]                  err_cnt
`endif
);

  localparam int unsigned W     = 32;
  localparam int unsigned BEATS = W / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned ERR_W = 16;

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4 ||
        BITS_PER_CYCLE == 8 || BITS_PER_CYCLE == 16 || BITS_PER_CYCLE == 32)) begin : g_bad_bpc
    $error("crc32_stream_checker: BITS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     crc_q, crc_d;
  logic [W-1:0]     data_q, data_d;   // payload shift register, or received CRC in RESULT
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             open_q, open_d;
  logic             res_valid_q, res_valid_d;
  logic             res_ok_q, res_ok_d;
  logic [W-1:0]     res_crc_q, res_crc_d;
`ifdef CRC32_CHK_ERRCNT_EN
  logic [ERR_W-1:0] err_q, err_d;
`endif

  logic             ready_c;
  logic             accept_c;
  logic [W-1:0]     fold_crc_c;

  assign ready_c   = rst_n && (state_q == ST_IDLE);
  assign accept_c  = s.s_valid && ready_c;
  assign s.s_ready = ready_c;

  // Fold the top BITS_PER_CYCLE bits of the shift register into the CRC, MSB first.
  always_comb begin : fold
    fold_crc_c = crc_q;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      fold_crc_c = {fold_crc_c[W-2:0], 1'b0} ^
                   ((data_q[5'(W - 1 - i)] ^ fold_crc_c[W-1]) ? CRC_POLY : '0);
    end
  end

  always_comb begin : next_state
    state_d     = state_q;
    crc_d       = crc_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    open_d      = open_q;
    res_valid_d = 1'b0;
    res_ok_d    = res_ok_q;
    res_crc_d   = res_crc_q;
`ifdef CRC32_CHK_ERRCNT_EN
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          data_d = s.s_data;
          cnt_d  = '0;
          if (s.s_last) begin
            state_d = ST_RESULT;
            open_d  = 1'b0;
          end else begin
            state_d = ST_SHIFT;
            open_d  = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        crc_d  = fold_crc_c;
        data_d = data_q << BITS_PER_CYCLE;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BEATS - 1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_RESULT: begin
        res_valid_d = 1'b1;
        res_ok_d    = (data_q == crc_q);
        res_crc_d   = crc_q;
        crc_d       = CRC_INIT;
        state_d     = ST_IDLE;
`ifdef CRC32_CHK_ERRCNT_EN
        if ((data_q != crc_q) && (err_q != {ERR_W{1'b1}})) begin
          err_d = err_q + ERR_W'(1);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin : regs
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      crc_q       <= CRC_INIT;
      data_q      <= '0;
      cnt_q       <= '0;
      open_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_ok_q    <= 1'b0;
      res_crc_q   <= '0;
`ifdef CRC32_CHK_ERRCNT_EN
      err_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      open_q      <= open_d;
      res_valid_q <= res_valid_d;
      res_ok_q    <= res_ok_d;
      res_crc_q   <= res_crc_d;
`ifdef CRC32_CHK_ERRCNT_EN
      err_q       <= err_d;
`endif
    end
  end

  assign res_valid = res_valid_q;
  assign res_ok    = res_ok_q;
  assign res_crc   = res_crc_q;
  assign busy      = (state_q == ST_SHIFT) || open_q;
`ifdef CRC32_CHK_ERRCNT_EN
  assign err_cnt   = err_q;
`endif

endmodule

// File: tb/tb_crc32_stream_checker.sv
// Scoreboard bench for crc32_stream_checker: three instances (1/8/32 bits per cycle) run the same
// directed packets in turn; one monitor checks results, latency, busy, ready stall and reset state.
module tb_crc32_stream_checker;

  localparam int unsigned NL   = 3;
  localparam int unsigned BPC_TBL [NL] = '{1, 8, 32};
  localparam logic [31:0] POLY = 32'h04C11DB7;

  typedef struct packed {
    logic [31:0] crc;
    logic        ok;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        rst_edge = 1'b1;

  logic [31:0] drv_data  [NL];
  logic        drv_valid [NL];
  logic        drv_last  [NL];
  logic        rdy_a     [NL];
  logic        rv_a      [NL];
  logic        ok_a      [NL];
  logic [31:0] crc_a     [NL];
  logic        busy_a    [NL];
`ifdef CRC32_CHK_ERRCNT_EN
  logic [15:0] err_a     [NL];
`endif

  exp_t        sb_q [NL][$];
  int          checks   = 0;
  int          failures = 0;
  int          tmo_cnt  = 0;
  bit          done     = 1'b0;
  bit          fin      = 1'b0;

  int          age     [NL];
  int          rlow    [NL];
  bit          armed   [NL];
  bit          open_m  [NL];
  logic [15:0] exp_err [NL];

  for (genvar g = 0; g < NL; g++) begin : g_lane
    crc32_stream_checker_if bus ();
    assign bus.s_data  = drv_data[g];
    assign bus.s_valid = drv_valid[g];
    assign bus.s_last  = drv_last[g];
    assign rdy_a[g]    = bus.s_ready;

    crc32_stream_checker #(
      .CRC_POLY      (POLY),
      .CRC_INIT      (32'h00000000),
      .BITS_PER_CYCLE(BPC_TBL[g])
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s        (bus),
      .res_valid(rv_a[g]),
      .res_ok   (ok_a[g]),
      .res_crc  (crc_a[g]),
      .busy     (busy_a[g])
`ifdef CRC32_CHK_ERRCNT_EN
      ,
      .err_cnt  (err_a[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rst_edge <= rst_n;

  // Bit-serial golden CRC over one 32-bit word.
  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    logic [31:0] dd;
    r  = c;
    dd = d;
    for (int i = 0; i < 32; i++) begin
      r  = {r[30:0], 1'b0} ^ ((dd[31] ^ r[31]) ? POLY : 32'h0);
      dd = dd << 1;
    end
    return r;
  endfunction

  task automatic chk(input int l, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL lane%0d %s: got %h, expected %h (t=%0t)", l, nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    for (int l = 0; l < NL; l++) begin
      if (!rst_edge) begin
        age[l]     = -1;
        armed[l]   = 1'b0;
        open_m[l]  = 1'b0;
        exp_err[l] = 16'h0000;
        chk(l, "rst_res_valid", 32'(rv_a[l]), 32'd0);
        chk(l, "rst_res_ok", 32'(ok_a[l]), 32'd0);
        chk(l, "rst_res_crc", crc_a[l], 32'h0);
        chk(l, "rst_busy", 32'(busy_a[l]), 32'd0);
        chk(l, "rst_ready", 32'(rdy_a[l]), 32'(rst_n));
`ifdef CRC32_CHK_ERRCNT_EN
        chk(l, "rst_err_cnt", 32'(err_a[l]), 32'd0);
`endif
      end else begin
        if (age[l] >= 0) age[l]++;
        chk(l, "busy", 32'(busy_a[l]), 32'(open_m[l]));
        if (rv_a[l]) begin
          chk(l, "latency", 32'(age[l]), 32'd2);
          chk(l, "pending_result", 32'(sb_q[l].size() > 0), 32'd1);
          if (sb_q[l].size() > 0) begin
            e = sb_q[l].pop_front();
            chk(l, "res_ok", 32'(ok_a[l]), 32'(e.ok));
            chk(l, "res_crc", crc_a[l], e.crc);
`ifdef CRC32_CHK_ERRCNT_EN
            if (!e.ok && exp_err[l] != 16'hFFFF) exp_err[l]++;
            chk(l, "err_cnt", 32'(err_a[l]), 32'(exp_err[l]));
`endif
          end
          age[l] = -1;
        end else if (age[l] == 2) begin
          chk(l, "latency_missing_pulse", 32'(rv_a[l]), 32'd1);
          age[l] = -1;
        end
        if (armed[l]) begin
          if (!rdy_a[l]) begin
            rlow[l]++;
          end else begin
            chk(l, "ready_low_cycles", 32'(rlow[l]), 32'(32 / BPC_TBL[l]));
            armed[l] = 1'b0;
          end
        end
        if (drv_valid[l] && rdy_a[l]) begin
          if (drv_last[l]) begin
            age[l]    = 0;
            open_m[l] = 1'b0;
          end else begin
            armed[l]  = 1'b1;
            rlow[l]   = 0;
            open_m[l] = 1'b1;
          end
        end
      end
    end
    if (done && !fin) begin
      for (int l = 0; l < NL; l++) chk(l, "undelivered_results", 32'(sb_q[l].size()), 32'd0);
      chk(0, "handshake_timeouts", 32'(tmo_cnt), 32'd0);
      fin = 1'b1;
    end
  end

  // Present one word and hold it until accepted; called and returns at posedge+1.
  task automatic send(input int l, input logic [31:0] d, input logic lst);
    bit hs;
    hs           = 1'b0;
    drv_data[l]  = d;
    drv_last[l]  = lst;
    drv_valid[l] = 1'b1;
    for (int n = 0; n < 200 && !hs; n++) begin
      @(negedge clk);
      hs = rdy_a[l];
      @(posedge clk);
    end
    if (!hs) tmo_cnt++;
    #1;
    drv_valid[l] = 1'b0;
    drv_data[l]  = $urandom;
    drv_last[l]  = 1'($urandom);
  endtask

  task automatic expect_res(input int l, input logic [31:0] c, input logic o);
    sb_q[l].push_back('{crc: c, ok: o});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    logic [31:0] gold;
    for (int l = 0; l < NL; l++) begin
      drv_data[l]  = 32'h0;
      drv_valid[l] = 1'b0;
      drv_last[l]  = 1'b0;
      age[l]       = -1;
      rlow[l]      = 0;
      armed[l]     = 1'b0;
      open_m[l]    = 1'b0;
      exp_err[l]   = 16'h0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    gold = crc_ref(32'h00000000, 32'h54784573);
    for (int l = 0; l < NL; l++) begin
      // Good CRC, then corrupted CRC word.
      expect_res(l, 32'h04C11DB7, 1'b1);
      send(l, 32'h00000001, 1'b0);
      send(l, 32'h04C11DB7, 1'b1);
      idle(2);
      expect_res(l, 32'h04C11DB7, 1'b0);
      send(l, 32'h00000001, 1'b0);
      send(l, 32'h04C11DB6, 1'b1);
      // Two packets back-to-back.
      expect_res(l, 32'h09823B6E, 1'b1);
      expect_res(l, 32'h00000000, 1'b1);
      send(l, 32'h00000002, 1'b0);
      send(l, 32'h09823B6E, 1'b1);
      send(l, 32'h00000000, 1'b0);
      send(l, 32'h00000000, 1'b1);
      idle(3);
      // Arbitrary payload against the bit-serial reference.
      expect_res(l, gold, 1'b1);
      send(l, 32'h54784573, 1'b0);
      send(l, gold, 1'b1);
      // Empty packets.
      expect_res(l, 32'h00000000, 1'b1);
      send(l, 32'h00000000, 1'b1);
      expect_res(l, 32'h00000000, 1'b0);
      send(l, 32'h00000001, 1'b1);
      idle(4);
      // Abort a packet mid-fold with a one-cycle reset, then a clean packet.
      send(l, 32'h00000001, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);
      expect_res(l, 32'h04C11DB7, 1'b1);
      send(l, 32'h00000001, 1'b0);
      send(l, 32'h04C11DB7, 1'b1);
      idle(5);
    end

    done = 1'b1;
    for (int n = 0; n < 10 && !fin; n++) @(posedge clk);
    if (!fin) begin
      $display("FAIL monitor_final: monitor did not complete end-of-run checks");
      $fatal(1, "monitor stalled");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
